escaner_teclado_hex: RTL and testbench



---
 rtl/escaner_teclado_hex_pkg.sv | 32 +++
 rtl/escaner_teclado_hex_sincronizador_2ff.sv | 23 ++
 rtl/escaner_teclado_hex.sv | 102 ++++++++++
 tb/tb_escaner_teclado_hex.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/escaner_teclado_hex_pkg.sv
// Shared definitions for the hex keypad scanner: FSM states, key map and row pattern.
package escaner_teclado_hex_pkg;

    typedef enum logic [1:0] {
        BARRIDO       = 2'd0,
        ANTIRREBOTE   = 2'd1,
        VALIDA        = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam logic [3:0] FILAS_RESET = 4'b1110;
    localparam logic [3:0] SIN_TECLA   = 4'b1111;

    // Indexed by {row, column}
    localparam logic [3:0] MAPA_TECLAS [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Lowest active-low column wins when several are pressed
    function automatic logic [1:0] primera_columna(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/escaner_teclado_hex_sincronizador_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle for active-low lines).
module sincronizador_2ff #(
    parameter int unsigned ANCHO = 4
) (
    input  logic             reloj,
    input  logic             reset_n,
    input  logic [ANCHO-1:0] asinc,
    output logic [ANCHO-1:0] sinc
);

    logic [ANCHO-1:0] etapa1;

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            etapa1 <= '1;
            sinc   <= '1;
        end else begin
            etapa1 <= asinc;
            sinc   <= etapa1;
        end
    end

endmodule

// File: rtl/escaner_teclado_hex.sv
// 4x4 hex keypad scanner with press/release debounce and a one-cycle valid pulse.
module escaner_teclado_hex
    import escaner_teclado_hex_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic       Reloj,
    input  logic       Reset_n,
    input  logic [3:0] Columnas,
    output logic [3:0] Filas,
    output logic [3:0] Codigo,
    output logic       TeclaValida,
    output logic       TeclaPresionada
);

    localparam int unsigned ANCHO_BARRIDO = $clog2(SCAN_DIV);
    localparam int unsigned ANCHO_REBOTE  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [ANCHO_BARRIDO-1:0] ULTIMO_BARRIDO = ANCHO_BARRIDO'(SCAN_DIV - 1);
    localparam logic [ANCHO_REBOTE-1:0]  ULTIMO_REBOTE  = ANCHO_REBOTE'(DEBOUNCE_CYCLES - 1);

    estado_t                  estado;
    logic [1:0]               fila;
    logic [3:0]               patron;
    logic [3:0]               col_sinc;
    logic [ANCHO_BARRIDO-1:0] cnt_barrido;
    logic [ANCHO_REBOTE-1:0]  cnt_rebote;

    sincronizador_2ff #(
        .ANCHO(4)
    ) u_sinc_columnas (
        .reloj  (Reloj),
        .reset_n(Reset_n),
        .asinc  (Columnas),
        .sinc   (col_sinc)
    );

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            estado          <= BARRIDO;
            fila            <= '0;
            Filas           <= FILAS_RESET;
            patron          <= SIN_TECLA;
            cnt_barrido     <= '0;
            cnt_rebote      <= '0;
            Codigo          <= '0;
            TeclaValida     <= 1'b0;
            TeclaPresionada <= 1'b0;
        end else begin
            TeclaValida <= 1'b0;
            unique case (estado)
                BARRIDO: begin
                    if (cnt_barrido != ULTIMO_BARRIDO) begin
                        cnt_barrido <= cnt_barrido + 1'b1;
                    end else begin
                        cnt_barrido <= '0;
                        if (col_sinc == SIN_TECLA) begin
                            Filas <= {Filas[2:0], Filas[3]};
                            fila  <= fila + 1'b1;
                        end else begin
                            patron     <= col_sinc;
                            cnt_rebote <= '0;
                            estado     <= ANTIRREBOTE;
                        end
                    end
                end
                ANTIRREBOTE: begin
                    // A mismatch retries the same row with a fresh dwell
                    if (col_sinc != patron) begin
                        cnt_barrido <= '0;
                        estado      <= BARRIDO;
                    end else if (cnt_rebote == ULTIMO_REBOTE) begin
                        estado <= VALIDA;
                    end else begin
                        cnt_rebote <= cnt_rebote + 1'b1;
                    end
                end
                VALIDA: begin
                    Codigo          <= MAPA_TECLAS[{fila, primera_columna(patron)}];
                    TeclaValida     <= 1'b1;
                    TeclaPresionada <= 1'b1;
                    cnt_rebote      <= '0;
                    estado          <= ESPERA_SOLTAR;
                end
                ESPERA_SOLTAR: begin
                    if (col_sinc != SIN_TECLA) begin
                        cnt_rebote <= '0;
                    end else if (cnt_rebote == ULTIMO_REBOTE) begin
                        TeclaPresionada <= 1'b0;
                        Filas           <= {Filas[2:0], Filas[3]};
                        fila            <= fila + 1'b1;
                        cnt_barrido     <= '0;
                        estado          <= BARRIDO;
                    end else begin
                        cnt_rebote <= cnt_rebote + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escaner_teclado_hex.sv
// Directed bench for escaner_teclado_hex with a keypad matrix model and an expected-code queue.
module tb_escaner_teclado_hex;

    localparam int unsigned SCAN_DIV        = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 8;

    logic       Reloj = 1'b0;
    logic       Reset_n;
    logic [3:0] Columnas;
    logic [3:0] Filas;
    logic [3:0] Codigo;
    logic       TeclaValida;
    logic       TeclaPresionada;

    logic [3:0]  teclas [4];
    logic [3:0]  esperados [$];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned pulsos     = 0;

    escaner_teclado_hex #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .Reloj          (Reloj),
        .Reset_n        (Reset_n),
        .Columnas       (Columnas),
        .Filas          (Filas),
        .Codigo         (Codigo),
        .TeclaValida    (TeclaValida),
        .TeclaPresionada(TeclaPresionada)
    );

    always #5 Reloj = ~Reloj;

    // Passive keypad: a held key pulls its column low while its row is driven low
    always_comb begin
        Columnas = '1;
        for (int r = 0; r < 4; r++)
            if (Filas[r] === 1'b0) Columnas = Columnas & ~teclas[r];
    end

    always @(negedge Reloj) begin
        logic [3:0] esperado;
        if (TeclaValida === 1'b1) begin
            pulsos++;
            compared++;
            assert (esperados.size() != 0) else begin
                mismatched++;
                $error("FAIL pulso_inesperado: observed codigo %0h, expected no pulse", Codigo);
            end
            if (esperados.size() != 0) begin
                esperado = esperados.pop_front();
                compared++;
                assert (Codigo === esperado) else begin
                    mismatched++;
                    $error("FAIL codigo: observed %0h expected %0h", Codigo, esperado);
                end
            end
        end
    end

    task automatic chequear(input string tag, input logic [7:0] obs, input logic [7:0] req);
        compared++;
        assert (obs === req) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic ciclos(input int unsigned n);
        repeat (n) begin
            @(negedge Reloj);
            #1;
        end
    endtask

    task automatic esperar_pulsos(input int unsigned n, input string tag);
        int unsigned k = 0;
        while (pulsos < n && k < 300) begin
            ciclos(1);
            k++;
        end
        chequear(tag, 8'(pulsos), 8'(n));
    endtask

    task automatic esperar_soltado(input string tag);
        int unsigned k = 0;
        while (TeclaPresionada !== 1'b0 && k < 300) begin
            ciclos(1);
            k++;
        end
        chequear(tag, {7'd0, TeclaPresionada}, 8'd0);
    endtask

    task automatic esperar_fila3();
        int unsigned k = 0;
        while (Filas === 4'b0111 && k < 100) begin
            ciclos(1);
            k++;
        end
        while (Filas !== 4'b0111 && k < 100) begin
            ciclos(1);
            k++;
        end
        chequear("llegar_fila3", {4'd0, Filas}, 8'h07);
    endtask

    initial begin
        logic [3:0] filas_req;
        for (int r = 0; r < 4; r++) teclas[r] = '0;
        Reset_n = 1'b1;
        #1 Reset_n = 1'b0;
        ciclos(3);
        chequear("reset_filas", {4'd0, Filas}, 8'h0E);
        chequear("reset_codigo", {4'd0, Codigo}, 8'h00);
        chequear("reset_valida", {7'd0, TeclaValida}, 8'h00);
        chequear("reset_presionada", {7'd0, TeclaPresionada}, 8'h00);
        Reset_n = 1'b1;

        // 1: idle scan, row changes every SCAN_DIV cycles
        for (int k = 0; k < 64; k++) begin
            if (k % 4 == 1) begin
                filas_req = ~(4'd1 << ((k / 4) % 4));
                chequear("barrido_filas", {4'd0, Filas}, {4'd0, filas_req});
            end
            ciclos(1);
        end
        chequear("barrido_sin_pulsos", 8'(pulsos), 8'd0);

        // 2: key "5", held then released
        teclas[1][1] = 1'b1;
        esperados.push_back(4'h5);
        esperar_pulsos(1, "pulso_5");
        ciclos(40);
        chequear("presionada_5", {7'd0, TeclaPresionada}, 8'h01);
        teclas[1][1] = 1'b0;
        ciclos(9);
        chequear("presionada_antes_soltar", {7'd0, TeclaPresionada}, 8'h01);
        ciclos(1);
        chequear("soltada_5", {7'd0, TeclaPresionada}, 8'h00);
        ciclos(20);
        chequear("codigo_retenido_5", {4'd0, Codigo}, 8'h05);
        chequear("un_pulso_5", 8'(pulsos), 8'd1);

        // 3: "#" with contact bounce on row 3
        esperar_fila3();
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) teclas[3][2] = ~teclas[3][2];
            ciclos(1);
        end
        chequear("sin_pulso_rebote", 8'(pulsos), 8'd1);
        teclas[3][2] = 1'b1;
        esperados.push_back(4'hF);
        esperar_pulsos(2, "pulso_F");
        teclas[3][2] = 1'b0;
        esperar_soltado("soltada_F");

        // 4: "A" held, then "1" added on the same row
        teclas[0][3] = 1'b1;
        esperados.push_back(4'hA);
        esperar_pulsos(3, "pulso_A");
        ciclos(5);
        teclas[0][0] = 1'b1;
        ciclos(30);
        chequear("segunda_tecla_ignorada", 8'(pulsos), 8'd3);
        teclas[0][3] = 1'b0;
        ciclos(30);
        chequear("presionada_con_1", {7'd0, TeclaPresionada}, 8'h01);
        chequear("1_sigue_ignorada", 8'(pulsos), 8'd3);
        teclas[0][0] = 1'b0;
        esperar_soltado("soltada_A1");
        ciclos(40);
        chequear("sin_pulso_tras_A", 8'(pulsos), 8'd3);
        chequear("codigo_retenido_A", {4'd0, Codigo}, 8'h0A);

        // 5: "7" and "9" together, lowest column wins
        teclas[2] = 4'b0101;
        esperados.push_back(4'h7);
        esperar_pulsos(4, "pulso_7");
        teclas[2] = 4'b0000;
        esperar_soltado("soltada_79");

        // 6: reset in the middle of debouncing "0"
        esperar_fila3();
        teclas[3][1] = 1'b1;
        ciclos(7);
        Reset_n = 1'b0;
        #1;
        chequear("reset_async_filas", {4'd0, Filas}, 8'h0E);
        chequear("reset_async_codigo", {4'd0, Codigo}, 8'h00);
        chequear("reset_async_valida", {7'd0, TeclaValida}, 8'h00);
        chequear("reset_async_presionada", {7'd0, TeclaPresionada}, 8'h00);
        chequear("sin_pulso_en_antirrebote", 8'(pulsos), 8'd4);
        ciclos(3);
        Reset_n = 1'b1;
        ciclos(10);
        chequear("sin_pulso_rancio", 8'(pulsos), 8'd4);
        esperados.push_back(4'h0);
        esperar_pulsos(5, "pulso_0");
        teclas[3][1] = 1'b0;
        esperar_soltado("soltada_0");
        ciclos(5);

        chequear("cola_vacia", 8'(esperados.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
